// File: rtl/busca_controle_pkg.sv
// Shared control-state and instruction-format codes for fetch, decode and execute.
// Also holds the PC-update selector used between the controller and its next-PC calculator.
package busca_controle_pkg;

  typedef enum logic [3:0] {
    BUSCA      = 4'b0000,
    DECODIFICA = 4'b0001,
    EXECUTA    = 4'b0010,
    MEMORIA    = 4'b0011,
    ESCRITA    = 4'b0100
  } estado_t;

  localparam logic [2:0] TIPO_LOAD   = 3'b000;
  localparam logic [2:0] TIPO_ALU_I  = 3'b001;
  localparam logic [2:0] TIPO_STORE  = 3'b010;
  localparam logic [2:0] TIPO_R      = 3'b011;
  localparam logic [2:0] TIPO_DESVIO = 3'b110;

  localparam int IMM_WIDTH = 12;

  typedef enum logic [1:0] {
    SEL_MANTEM     = 2'b00,
    SEL_INCREMENTA = 2'b01,
    SEL_DESVIO     = 2'b10
  } sel_pc_t;

endpackage

// File: rtl/busca_controle_calc_proximo_pc.sv
// Next-PC calculator: sequential +4 or a taken branch relative to pc_atual,
// using decode's unsigned magnitude plus sign-bit immediate format.
module calc_proximo_pc
  import busca_controle_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0]  i_pc,
  input  logic [PC_WIDTH-1:0]  i_pc_atual,
  input  logic [IMM_WIDTH-1:0] i_immediate,
  input  logic                 i_negativo,
  input  logic                 i_desvio_tomado,
  input  sel_pc_t              i_select,
  output logic [PC_WIDTH-1:0]  o_proximo_pc
);

  logic [PC_WIDTH-1:0] w_imm_ext;
  logic [PC_WIDTH-1:0] w_alvo;

  assign w_imm_ext = PC_WIDTH'(i_immediate);
  assign w_alvo    = i_negativo ? (i_pc_atual - w_imm_ext) : (i_pc_atual + w_imm_ext);

  always_comb begin
    o_proximo_pc = i_pc;
    case (i_select)
      SEL_INCREMENTA: o_proximo_pc = i_pc + PC_WIDTH'(4);
      SEL_DESVIO:     o_proximo_pc = i_desvio_tomado ? w_alvo : i_pc;
      default:        o_proximo_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/busca_controle.sv
// Multicycle fetch/control unit: owns PC and instruction register, sequences stages.
// states: BUSCA fetch | DECODIFICA decode latch | EXECUTA dispatch by tipo | MEMORIA dmem wait | ESCRITA rf write
module busca_controle
  import busca_controle_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          instrucao,
  output logic [3:0]           estado,
  output logic [PC_WIDTH-1:0]  pc_atual,
  input  logic [2:0]           tipo,
  input  logic [IMM_WIDTH-1:0] immediate,
  input  logic                 negativo,
  input  logic                 desvio_tomado,
  input  logic                 dmem_done,
  output logic                 escreve_reg,
  output logic                 instr_invalida
);

  estado_t             r_estado;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_pc_atual;
  logic [31:0]         r_instrucao;
  logic                r_instr_invalida;

  estado_t             w_estado_nxt;
  sel_pc_t             w_sel_pc;
  logic                w_captura;
  logic                w_invalida_nxt;
  logic [PC_WIDTH-1:0] w_pc_nxt;

  calc_proximo_pc #(
    .PC_WIDTH(PC_WIDTH)
  ) u_calc_proximo_pc (
    .i_pc           (r_pc),
    .i_pc_atual     (r_pc_atual),
    .i_immediate    (immediate),
    .i_negativo     (negativo),
    .i_desvio_tomado(desvio_tomado),
    .i_select       (w_sel_pc),
    .o_proximo_pc   (w_pc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado         <= BUSCA;
      r_pc             <= RESET_PC;
      r_pc_atual       <= RESET_PC;
      r_instrucao      <= 32'h0;
      r_instr_invalida <= 1'b0;
    end else begin
      r_estado         <= w_estado_nxt;
      r_pc             <= w_pc_nxt;
      r_instr_invalida <= w_invalida_nxt;
      if (w_captura) begin
        r_instrucao <= imem_rdata;
        r_pc_atual  <= r_pc;
      end
    end
  end

  always_comb begin
    w_estado_nxt   = r_estado;
    w_sel_pc       = SEL_MANTEM;
    w_captura      = 1'b0;
    w_invalida_nxt = 1'b0;
    case (r_estado)
      BUSCA: begin
        if (imem_ready) begin
          w_captura    = 1'b1;
          w_sel_pc     = SEL_INCREMENTA;
          w_estado_nxt = DECODIFICA;
        end
      end
      DECODIFICA: w_estado_nxt = EXECUTA;
      EXECUTA: begin
        case (tipo)
          TIPO_LOAD, TIPO_STORE: w_estado_nxt = MEMORIA;
          TIPO_ALU_I, TIPO_R:    w_estado_nxt = ESCRITA;
          TIPO_DESVIO: begin
            w_estado_nxt = BUSCA;
            w_sel_pc     = SEL_DESVIO;
          end
          default: begin
            w_estado_nxt   = BUSCA;
            w_invalida_nxt = 1'b1;
          end
        endcase
      end
      MEMORIA: begin
        if (dmem_done) w_estado_nxt = (tipo == TIPO_LOAD) ? ESCRITA : BUSCA;
      end
      ESCRITA: w_estado_nxt = BUSCA;
      default: w_estado_nxt = BUSCA;
    endcase
  end

  // Request is qualified by rst_n so it drops the instant reset is applied.
  assign imem_req       = rst_n & (r_estado == BUSCA);
  assign imem_addr      = r_pc;
  assign escreve_reg    = (r_estado == ESCRITA);
  assign estado         = r_estado;
  assign instrucao      = r_instrucao;
  assign pc_atual       = r_pc_atual;
  assign instr_invalida = r_instr_invalida;

endmodule

// File: doc/busca_controle.md
Name: busca_controle

Overview:
- Multicycle fetch and control unit sitting directly upstream of the decode stage.
- Owns the PC and the instruction register, and fetches from instruction memory over a req/ready handshake.
- Drives `instrucao` and the 4-bit `estado` that the decode stage and later stages qualify on; decode latches its fields on the clock edge while `estado` = 4'b0001.
- Sequences execute/memory/writeback per the decoded `tipo` and applies taken-branch PC updates using decode's magnitude + `negativo` immediate format.

Parameters:
- PC_WIDTH, 32, width of PC and instruction-memory address.
- RESET_PC, 32'h0000_0000, PC value after reset; must be a multiple of 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_WIDTH  fetch address.
- imem_ready  in  1  imem_rdata valid; completes the fetch.
- imem_rdata  in  32  fetched instruction word.
- instrucao  out  32  instruction register, feeds decode.
- estado  out  4  current control state, broadcast to all stages.
- pc_atual  out  PC_WIDTH  address of the instruction in flight.
- tipo  in  3  format code registered by decode.
- immediate  in  12  immediate magnitude from decode.
- negativo  in  1  immediate sign from decode (1 = subtract).
- desvio_tomado  in  1  branch condition from execute, valid in EXECUTA.
- dmem_done  in  1  data-memory access complete.
- escreve_reg  out  1  register-file write enable.
- instr_invalida  out  1  one-cycle pulse on unsupported tipo.

Behaviour:
- Reset (async, rst_n low), effective immediately:
  - estado = BUSCA (4'b0000); pc = RESET_PC; pc_atual = RESET_PC; instrucao = 32'h0.
  - imem_req = 0; escreve_reg = 0; instr_invalida = 0.
  - Reset mid-operation abandons any in-flight fetch or memory access.
- All outputs are registered except imem_req, imem_addr and escreve_reg, which are decoded from estado and pc.
- State BUSCA (0000):
  - imem_req = 1 and imem_addr = pc, both held stable until imem_ready is sampled high.
  - On the edge with imem_ready = 1: instrucao <= imem_rdata; pc_atual <= pc; pc <= pc + 4, wrapping modulo 2^PC_WIDTH (0xFFFF_FFFC becomes 0x0); go to DECODIFICA.
  - imem_ready while not in BUSCA is ignored.
- State DECODIFICA (0001): one cycle; decode registers its fields; go to EXECUTA.
- State EXECUTA (0010): tipo is valid. Next state by tipo:
  - 000 (load) -> MEMORIA.
  - 010 (store) -> MEMORIA.
  - 001 (I-ALU) -> ESCRITA.
  - 011 (R) -> ESCRITA.
  - 110 (branch) -> BUSCA. If desvio_tomado = 1: pc <= negativo ? pc_atual - zero_ext(immediate) : pc_atual + zero_ext(immediate), modulo 2^PC_WIDTH. Otherwise pc is kept (already pc_atual + 4).
  - Any other tipo -> BUSCA with instr_invalida = 1 for exactly that transition cycle; pc unchanged.
- State MEMORIA (0011):
  - Wait while dmem_done = 0; no timeout.
  - On dmem_done = 1: a load goes to ESCRITA, a store goes to BUSCA.
  - tipo is sampled from the decode output, which stays stable because decode updates only in 0001.
- State ESCRITA (0100): escreve_reg = 1 for exactly one cycle; go to BUSCA.
- Unused estado encodings recover to BUSCA on the next edge.
- Cycle counts with zero-wait fetch:
  - branch: 3 cycles.
  - R / I-ALU: 4 cycles.
  - store: 4 cycles plus dmem wait.
  - load: 5 cycles plus dmem wait.

Decomposition:
- Shared package: state constants (BUSCA 0000, DECODIFICA 0001, EXECUTA 0010, MEMORIA 0011, ESCRITA 0100) and tipo codes (000, 001, 010, 011, 110), for use by decode, execute and this block.
- One natural sub-module, `calc_proximo_pc` (combinational):
  - Inputs: pc, pc_atual, immediate, negativo, desvio_tomado, select.
  - Output: next PC.
  - Holds the increment and signed-magnitude add/subtract so it can be unit-tested alone.

Test Plan:
- Reset release, imem_ready tied high, imem_rdata = R-type (opcode 0110011, tipo 011):
  - estado sequence is 0000, 0001, 0010, 0100, 0000.
  - escreve_reg is high only in 0100.
  - imem_addr goes 0x0 then 0x4.
- imem_ready held low for 3 cycles in BUSCA:
  - imem_req stays 1 and imem_addr stays constant.
  - instrucao updates only on the ready edge.
- Branch at pc_atual = 0x20, tipo 110, desvio_tomado = 1:
  - immediate = 0x010, negativo = 0 -> next fetch at 0x30.
  - immediate = 0x008, negativo = 1 -> next fetch at 0x18.
  - desvio_tomado = 0 -> next fetch at 0x24.
- Load with dmem_done delayed 2 cycles:
  - estado shows 0011 for 3 cycles, then 0100, then 0000.
  - Same test as a store: 0011 -> 0000 with no escreve_reg.
- Wrap and invalid tipo:
  - RESET_PC = 0xFFFF_FFFC -> second fetch address is 0x0.
  - tipo = 101 -> instr_invalida pulses one cycle and the flow returns to BUSCA.
- rst_n asserted mid-MEMORIA:
  - Outputs return to reset values asynchronously.
  - First fetch after release is at RESET_PC.
